dm_bus_master: RTL and testbench

//  Multi-cycle load/store unit between the MEM pipeline stage and the system bridge.

---
 rtl/dm_pkg.sv | 7 +
 rtl/dm_bus_master_if.sv | 22 ++
 rtl/dm_lane_align.sv | 46 ++++
 rtl/dm_bus_master.sv | 91 +++++++++
 tb/tb_dm_bus_master.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: access type codes, exception codes and FSM states shared by the load/store unit.
package dm_pkg;
  localparam logic [3:0] T_W = 4'b0000, T_H = 4'b0010, T_HU = 4'b0011, T_B = 4'b0100;
  localparam logic [3:0] T_BU = 4'b0101, T_WL = 4'b0110, T_WR = 4'b0111;
  localparam logic [4:0] EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_DBE = 5'd7, EXC_RI = 5'd10;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
endpackage

// File: rtl/dm_bus_master_if.sv
// dm_bus_master_if: MEM-stage request/response and system-bridge bus signals of the load/store unit.
interface dm_bus_master_if;
  logic        req_valid, req_we, req_ready;
  logic [3:0]  req_type;
  logic [31:0] req_addr, req_wd, req_rt_old, req_pc;
  logic        resp_valid, resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] resp_rd, resp_badvaddr, resp_pc;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wd, bus_rdata;
  modport master (
    input  req_valid, req_we, req_type, req_addr, req_wd, req_rt_old, req_pc, bus_rdata, bus_ack, bus_err,
    output req_ready, resp_valid, resp_rd, resp_exc, resp_exc_code, resp_badvaddr, resp_pc,
           bus_req, bus_we, bus_addr, bus_be, bus_wd
  );
  modport slave (
    output req_valid, req_we, req_type, req_addr, req_wd, req_rt_old, req_pc, bus_rdata, bus_ack, bus_err,
    input  req_ready, resp_valid, resp_rd, resp_exc, resp_exc_code, resp_badvaddr, resp_pc,
           bus_req, bus_we, bus_addr, bus_be, bus_wd
  );
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte enables, lane-shifted store data and alignment check for the incoming
// request, plus extension/merge of returned load data for the registered access.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [3:0]  stType,
  input  logic [1:0]  stOff,
  input  logic [31:0] stWd,
  input  logic [3:0]  ldType,
  input  logic [1:0]  ldOff,
  input  logic [31:0] rtOld,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wd,
  output logic [31:0] rd,
  output logic        unknown,
  output logic        misaligned
);
  logic        isH, isB;
  logic [15:0] lh;
  logic [7:0]  lb;
  always_comb begin
    isH = stType[3:1] == 3'b001;
    isB = stType[3:1] == 3'b010;
    unknown = !(stType inside {T_W, T_H, T_HU, T_B, T_BU, T_WL, T_WR});
    misaligned = (stType == T_W && stOff != 2'd0) || (isH && stOff[0]);
    be = stType == T_WL ? 4'b1111 >> (2'd3 - stOff) :
         stType == T_WR ? 4'b1111 << stOff :
         isB ? 4'b0001 << stOff :
         isH ? (stOff[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = stType == T_WL ? stWd >> {~stOff, 3'b000} :
         stType == T_WR ? stWd << {stOff, 3'b000} :
         isB ? {24'b0, stWd[7:0]} << {stOff, 3'b000} :
         isH ? {16'b0, stWd[15:0]} << {stOff[1], 4'b0000} : stWd;
    lh = ldOff[1] ? rdata[31:16] : rdata[15:0];
    lb = 8'(rdata >> {ldOff, 3'b000});
    // WL/WR keep the rt bytes the unaligned word does not cover
    rd = ldType == T_H  ? {{16{lh[15]}}, lh} :
         ldType == T_HU ? {16'b0, lh} :
         ldType == T_B  ? {{24{lb[7]}}, lb} :
         ldType == T_BU ? {24'b0, lb} :
         ldType == T_WL ? (rdata << {~ldOff, 3'b000}) | (rtOld & (32'h00FF_FFFF >> {ldOff, 3'b000})) :
         ldType == T_WR ? (rdata >> {ldOff, 3'b000}) | (rtOld & ~(32'hFFFF_FFFF >> {ldOff, 3'b000})) :
         rdata;
  end
endmodule

// File: rtl/dm_bus_master.sv
// dm_bus_master: multi-cycle load/store unit; one access per handshake, bus request held until
// ack/err/timeout, then a one-cycle response carrying load data or an exception.
module dm_bus_master
  import dm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  dm_bus_master_if.master d
);
  state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0] addrR, rtOld;
  logic [3:0]  ldType;
  logic        isStore;
  logic [3:0]  be;
  logic [31:0] wd, rd;
  logic        unknown, misaligned, busFault;
  assign busFault = d.bus_err | ~d.bus_ack;
  dm_lane_align lane (
    .stType(d.req_type), .stOff(d.req_addr[1:0]), .stWd(d.req_wd),
    .ldType(ldType), .ldOff(addrR[1:0]), .rtOld(rtOld), .rdata(d.bus_rdata),
    .be(be), .wd(wd), .rd(rd), .unknown(unknown), .misaligned(misaligned)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      addrR <= '0;
      rtOld <= '0;
      ldType <= '0;
      isStore <= 1'b0;
      d.req_ready <= 1'b1;
      d.resp_valid <= 1'b0;
      d.resp_rd <= '0;
      d.resp_exc <= 1'b0;
      d.resp_exc_code <= '0;
      d.resp_badvaddr <= '0;
      d.resp_pc <= '0;
      d.bus_req <= 1'b0;
      d.bus_we <= 1'b0;
      d.bus_addr <= '0;
      d.bus_be <= '0;
      d.bus_wd <= '0;
    end else begin
      case (state)
        IDLE: if (d.req_valid) begin
          addrR <= d.req_addr;
          rtOld <= d.req_rt_old;
          ldType <= d.req_type;
          isStore <= d.req_we;
          d.resp_pc <= d.req_pc;
          d.req_ready <= 1'b0;
          if (unknown || misaligned) begin
            state <= RESP;
            d.resp_valid <= 1'b1;
            d.resp_exc <= 1'b1;
            d.resp_exc_code <= unknown ? EXC_RI : d.req_we ? EXC_ADES : EXC_ADEL;
            d.resp_badvaddr <= d.req_addr;
            d.resp_rd <= '0;
          end else begin
            state <= BUS;
            d.bus_req <= 1'b1;
            d.bus_we <= d.req_we;
            d.bus_addr <= {d.req_addr[31:2], 2'b00};
            d.bus_be <= be;
            d.bus_wd <= wd;
          end
        end
        BUS: if (d.bus_err || d.bus_ack || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state <= RESP;
          cnt <= '0;
          d.bus_req <= 1'b0;
          d.resp_valid <= 1'b1;
          d.resp_exc <= busFault;
          d.resp_exc_code <= busFault ? EXC_DBE : 5'd0;
          d.resp_badvaddr <= busFault ? addrR : 32'd0;
          d.resp_rd <= (busFault || isStore) ? 32'd0 : rd;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          state <= IDLE;
          d.resp_valid <= 1'b0;
          d.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_bus_master.sv
// tb_dm_bus_master: randomized and directed accesses checked every cycle against a byte-level model.
module tb_dm_bus_master;
  localparam int TO = 15;
  logic clk, reset;
  int total = 0, passed = 0;
  logic eReady, eBusReq, eBusWe, eRespValid, eExc;
  logic [3:0] eBe;
  logic [4:0] eCode;
  logic [31:0] eAddr, eWd, eRd, eBad, ePc;
  dm_bus_master_if ifc();
  dm_bus_master #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (.clk(clk), .reset(reset), .d(ifc));
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [7:0] byteOf(input logic [31:0] x, input int k);
    return x[8*k +: 8];
  endfunction

  // Reference: which memory lanes an access touches and what each result byte comes from
  function automatic void model(input logic [3:0] t, input logic we, input logic [31:0] a, wd, rt, mem,
                                output logic exc, output logic [4:0] code, output logic [3:0] be,
                                output logic [31:0] bwd, output logic [31:0] rd);
    int b, h, lo, hi, base;
    logic known, mis;
    logic [15:0] hw;
    logic [7:0] bt;
    b = int'(a[1:0]);
    h = int'(a[1]);
    known = t inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    mis = (t == 4'd0 && b != 0) || ((t == 4'd2 || t == 4'd3) && a[0]);
    exc = !known || mis;
    code = !known ? 5'd10 : mis ? (we ? 5'd5 : 5'd4) : 5'd0;
    lo = 0; hi = 3; base = 0;
    if (t == 4'd2 || t == 4'd3) begin lo = 2*h; hi = 2*h + 1; end
    if (t == 4'd4 || t == 4'd5) begin lo = b; hi = b; end
    if (t == 4'd6) begin lo = 0; hi = b; base = 3 - b; end
    if (t == 4'd7) begin lo = b; hi = 3; end
    be = 0; bwd = 0;
    for (int i = lo; i <= hi; i++) begin
      be[i] = 1'b1;
      bwd[8*i +: 8] = byteOf(wd, i - lo + base);
    end
    hw = h ? mem[31:16] : mem[15:0];
    bt = byteOf(mem, b);
    rd = mem;
    if (t == 4'd2 || t == 4'd3) rd = {{16{t == 4'd2 && hw[15]}}, hw};
    if (t == 4'd4 || t == 4'd5) rd = {{24{t == 4'd4 && bt[7]}}, bt};
    if (t == 4'd6) for (int j = 0; j < 4; j++) rd[8*j +: 8] = (j >= 3 - b) ? byteOf(mem, j - (3 - b)) : byteOf(rt, j);
    if (t == 4'd7) for (int j = 0; j < 4; j++) rd[8*j +: 8] = (j <= 3 - b) ? byteOf(mem, j + b) : byteOf(rt, j);
  endfunction

  always @(negedge clk) begin
    chk("req_ready", ifc.req_ready, eReady);
    chk("bus_req", ifc.bus_req, eBusReq);
    chk("resp_valid", ifc.resp_valid, eRespValid);
    if (eBusReq) begin
      chk("bus_we", ifc.bus_we, eBusWe);
      chk("bus_addr", ifc.bus_addr, eAddr);
      chk("bus_be", ifc.bus_be, eBe);
      chk("bus_wd", ifc.bus_wd, eWd);
    end
    if (eRespValid) begin
      chk("resp_rd", ifc.resp_rd, eRd);
      chk("resp_exc", ifc.resp_exc, eExc);
      chk("resp_exc_code", ifc.resp_exc_code, eCode);
      chk("resp_badvaddr", ifc.resp_badvaddr, eBad);
      chk("resp_pc", ifc.resp_pc, ePc);
    end
  end

  task automatic expIdle();
    eReady = 1; eBusReq = 0; eRespValid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ack, 1 err, 2 ack+err, 3 never answer
  task automatic doTxn(input logic [3:0] t, input logic we, input logic [31:0] a, wd, rt, pc, mem,
                       input int mode, input int dly);
    logic exc, fault, hit;
    logic [4:0] code;
    logic [3:0] be;
    logic [31:0] bwd, rd;
    model(t, we, a, wd, rt, mem, exc, code, be, bwd, rd);
    ifc.req_valid = 1; ifc.req_type = t; ifc.req_we = we; ifc.req_addr = a;
    ifc.req_wd = wd; ifc.req_rt_old = rt; ifc.req_pc = pc;
    tick();
    ifc.req_valid = 0; ifc.req_type = 4'($urandom); ifc.req_we = 1'($urandom);
    ifc.req_addr = $urandom; ifc.req_wd = $urandom; ifc.req_rt_old = $urandom; ifc.req_pc = $urandom;
    eReady = 0; ePc = pc;
    if (exc) begin
      eRespValid = 1; eExc = 1; eCode = code; eBad = a; eRd = 0;
    end else begin
      eBusReq = 1; eBusWe = we; eAddr = {a[31:2], 2'b00}; eBe = be; eWd = bwd;
      for (int c = 1; c <= TO; c++) begin
        hit = (mode != 3) && (c == dly);
        ifc.bus_rdata = hit ? mem : $urandom;
        ifc.bus_ack = hit && (mode == 0 || mode == 2);
        ifc.bus_err = hit && (mode == 1 || mode == 2);
        tick();
        ifc.bus_ack = 0; ifc.bus_err = 0;
        if (hit) break;
      end
      fault = (mode != 0);
      eBusReq = 0; eRespValid = 1; eExc = fault; eCode = fault ? 5'd7 : 5'd0;
      eBad = fault ? a : 32'd0; eRd = (fault || we) ? 32'd0 : rd;
    end
    tick();
    expIdle();
  endtask

  initial begin
    logic exc;
    logic [4:0] code;
    logic [3:0] be, t;
    logic [31:0] bwd, rd, a;
    logic [3:0] known [7] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0] unk [4] = '{4'd1, 4'd8, 4'd9, 4'd15};
    int r, sel;
    reset = 1; expIdle();
    ifc.req_valid = 0; ifc.req_we = 0; ifc.req_type = 0; ifc.req_addr = 0; ifc.req_wd = 0;
    ifc.req_rt_old = 0; ifc.req_pc = 0; ifc.bus_rdata = 0; ifc.bus_ack = 0; ifc.bus_err = 0;
    model(4'd0, 1, 32'h10, 32'hDEADBEEF, 0, 0, exc, code, be, bwd, rd);
    chk("pin_sw_be", be, 4'b1111); chk("pin_sw_wd", bwd, 32'hDEADBEEF);
    model(4'd4, 0, 32'h13, 0, 0, 32'h80FF0000, exc, code, be, bwd, rd);
    chk("pin_lb_rd", rd, 32'hFFFFFF80); chk("pin_lb_be", be, 4'b1000);
    model(4'd5, 0, 32'h13, 0, 0, 32'h80FF0000, exc, code, be, bwd, rd);
    chk("pin_lbu_rd", rd, 32'h00000080);
    model(4'd6, 0, 32'h01, 0, 32'h11223344, 32'hAABBCCDD, exc, code, be, bwd, rd);
    chk("pin_lwl_rd", rd, 32'hCCDD3344);
    model(4'd7, 0, 32'h01, 0, 32'h11223344, 32'hAABBCCDD, exc, code, be, bwd, rd);
    chk("pin_lwr_rd", rd, 32'h11AABBCC);
    model(4'd7, 1, 32'h02, 32'h12345678, 0, 0, exc, code, be, bwd, rd);
    chk("pin_swr_be", be, 4'b1100); chk("pin_swr_wd", bwd, 32'h56780000);
    model(4'd0, 0, 32'h12, 0, 0, 0, exc, code, be, bwd, rd);
    chk("pin_lw_mis", {exc, code}, {1'b1, 5'd4});
    model(4'd2, 1, 32'h11, 0, 0, 0, exc, code, be, bwd, rd);
    chk("pin_sh_mis", {exc, code}, {1'b1, 5'd5});
    repeat (2) tick();
    chk("rst_bus_addr", ifc.bus_addr, 0); chk("rst_bus_be", ifc.bus_be, 0);
    chk("rst_bus_wd", ifc.bus_wd, 0); chk("rst_resp_rd", ifc.resp_rd, 0);
    chk("rst_resp_code", ifc.resp_exc_code, 0); chk("rst_resp_pc", ifc.resp_pc, 0);
    reset = 0;
    tick();
    doTxn(4'd0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h400, 0, 0, 2);
    doTxn(4'd4, 0, 32'h13, 0, 0, 32'h404, 32'h80FF0000, 0, 1);
    doTxn(4'd5, 0, 32'h13, 0, 0, 32'h408, 32'h80FF0000, 0, 3);
    doTxn(4'd0, 0, 32'h12, 0, 0, 32'h40C, 0, 0, 1);
    doTxn(4'd2, 1, 32'h11, 32'hCAFE, 0, 32'h410, 0, 0, 1);
    doTxn(4'd6, 0, 32'h01, 0, 32'h11223344, 32'h414, 32'hAABBCCDD, 0, 1);
    doTxn(4'd7, 1, 32'h02, 32'h12345678, 0, 32'h418, 0, 0, 1);
    doTxn(4'd9, 0, 32'h20, 0, 0, 32'h41C, 0, 0, 1);
    doTxn(4'd0, 0, 32'h30, 0, 0, 32'h420, 32'h1234, 3, 1);
    doTxn(4'd0, 0, 32'h34, 0, 0, 32'h424, 32'h1234, 2, 4);
    doTxn(4'd3, 0, 32'h36, 0, 0, 32'h428, 32'h8001FFFF, 1, 2);
    doTxn(4'd2, 0, 32'h36, 0, 0, 32'h42C, 32'h8001FFFF, 0, TO);
    // reset while the bus request is outstanding
    ifc.req_valid = 1; ifc.req_type = 4'd0; ifc.req_we = 0; ifc.req_addr = 32'h100; ifc.req_pc = 32'h500;
    tick();
    ifc.req_valid = 0;
    eReady = 0; eBusReq = 1; eBusWe = 0; eAddr = 32'h100; eBe = 4'b1111; eWd = ifc.req_wd;
    tick();
    #1 reset = 1; expIdle();
    #1 chk("abort_bus_req", ifc.bus_req, 0); chk("abort_req_ready", ifc.req_ready, 1);
    tick();
    reset = 0; ifc.bus_ack = 1; ifc.bus_rdata = 32'h5A5A5A5A;
    tick();
    ifc.bus_ack = 0;
    repeat (3) tick();
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 7);
      t = sel < 7 ? known[sel] : unk[$urandom_range(0, 3)];
      a = $urandom;
      r = $urandom_range(0, 9);
      repeat ($urandom_range(0, 1)) tick();
      doTxn(t, 1'($urandom), a, $urandom, $urandom, $urandom, $urandom,
            r < 7 ? 0 : r == 7 ? 1 : r == 8 ? 2 : 3, $urandom_range(1, r < 5 ? 3 : TO));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end
endmodule
